// File: rtl/velocity_unit_converter.sv
// velocity_unit_converter
// Converts raw per-channel pod velocity (um/s) into display speed units.
// One shared restoring divider walks the channels round-robin: load a
// channel, run IN_WIDTH divide steps, store (with optional half-up rounding),
// then either load the next channel on the same edge or drop back to idle.
module velocity_unit_converter #(
  parameter int IN_WIDTH      = 32,
  parameter int DIV_WIDTH     = 19,
  parameter int NUM_CH        = 4,
  parameter int MPH_DIV       = 447039,
  parameter int KMH_DIV       = 277778,
  parameter int ROUND_NEAREST = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [NUM_CH*IN_WIDTH-1:0] velocity,
  output logic [NUM_CH*IN_WIDTH-1:0] speed,
  output logic [NUM_CH-1:0]          speed_valid,
  output logic                       busy,
  output logic                       scan_done
);

  localparam int CNT_W = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  // Divisor for a unit select; the raw modes divide by one.
  function automatic logic [DIV_WIDTH-1:0] sel_divisor(input logic [1:0] m);
    logic [DIV_WIDTH-1:0] d;
    case (m)
      2'd0:    d = DIV_WIDTH'(MPH_DIV);
      2'd1:    d = DIV_WIDTH'(KMH_DIV);
      default: d = DIV_WIDTH'(1'b1);
    endcase
    return d;
  endfunction

  state_t               state_r;
  logic [CH_W-1:0]      ch_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [IN_WIDTH-1:0]  dividend_r;
  logic [IN_WIDTH-1:0]  quot_r;
  logic [DIV_WIDTH:0]   rem_r;
  logic [DIV_WIDTH-1:0] divisor_r;
  logic [IN_WIDTH-1:0]  speed_arr_r [NUM_CH];
  logic [NUM_CH-1:0]    speed_valid_r;
  logic                 scan_done_r;
  logic                 busy_r;

  logic [IN_WIDTH-1:0]  vel_arr_s [NUM_CH];
  logic [CH_W-1:0]      ch_next_s;
  logic [CH_W-1:0]      load_ch_s;
  logic                 load_s;
  logic [DIV_WIDTH:0]   rem_shift_s;
  logic                 ge_s;
  logic [DIV_WIDTH:0]   rem_next_s;
  logic                 round_up_s;
  logic [IN_WIDTH-1:0]  result_s;

  // Unpack the flat velocity bus into per-channel words.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      vel_arr_s[c] = velocity[c*IN_WIDTH +: IN_WIDTH];
    end
  end

  // Channel sequencing: next pointer, and which channel a load event captures.
  always_comb begin
    if (ch_r == CH_W'(NUM_CH - 1)) begin
      ch_next_s = '0;
    end else begin
      ch_next_s = ch_r + CH_W'(1'b1);
    end
    if (state_r == ST_STORE) begin
      load_ch_s = ch_next_s;
    end else begin
      load_ch_s = ch_r;
    end
    load_s = enable && ((state_r == ST_IDLE) || (state_r == ST_STORE));
  end

  // One restoring divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift_s = {rem_r[DIV_WIDTH-1:0], dividend_r[IN_WIDTH-1]};
    ge_s        = (rem_shift_s >= {1'b0, divisor_r});
    if (ge_s) begin
      rem_next_s = rem_shift_s - {1'b0, divisor_r};
    end else begin
      rem_next_s = rem_shift_s;
    end
  end

  // Final result: half-up rounding on the remainder, saturating at all-ones.
  always_comb begin
    round_up_s = (ROUND_NEAREST != 0) && ({rem_r, 1'b0} >= {2'b00, divisor_r});
    if (round_up_s) begin
      if (&quot_r) begin
        result_s = '1;
      end else begin
        result_s = quot_r + IN_WIDTH'(1'b1);
      end
    end else begin
      result_s = quot_r;
    end
  end

  // Scan controller, divider datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ch_r          <= '0;
      cnt_r         <= '0;
      dividend_r    <= '0;
      quot_r        <= '0;
      rem_r         <= '0;
      divisor_r     <= '0;
      speed_valid_r <= '0;
      scan_done_r   <= 1'b0;
      busy_r        <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        speed_arr_r[c] <= '0;
      end
    end else begin
      speed_valid_r <= '0;
      scan_done_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
        end
        ST_DIV: begin
          rem_r      <= rem_next_s;
          quot_r     <= {quot_r[IN_WIDTH-2:0], ge_s};
          dividend_r <= {dividend_r[IN_WIDTH-2:0], 1'b0};
          cnt_r      <= cnt_r - CNT_W'(1'b1);
          if (cnt_r == '0) begin
            state_r <= ST_STORE;
          end
        end
        ST_STORE: begin
          speed_arr_r[ch_r]   <= result_s;
          speed_valid_r[ch_r] <= 1'b1;
          scan_done_r         <= (ch_r == CH_W'(NUM_CH - 1));
          ch_r                <= ch_next_s;
          state_r             <= ST_IDLE;
          busy_r              <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      // A load overrides the idle/return path above; mode and velocity are
      // sampled only here, so later changes never disturb a running conversion.
      if (load_s) begin
        dividend_r <= vel_arr_s[load_ch_s];
        divisor_r  <= sel_divisor(mode);
        rem_r      <= '0;
        quot_r     <= '0;
        cnt_r      <= CNT_W'(IN_WIDTH - 1);
        state_r    <= ST_DIV;
        busy_r     <= 1'b1;
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_out
      assign speed[g*IN_WIDTH +: IN_WIDTH] = speed_arr_r[g];
    end
  endgenerate

  assign speed_valid = speed_valid_r;
  assign scan_done   = scan_done_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_velocity_unit_converter.sv
// Self-checking bench for velocity_unit_converter: a cycle-level behavioural
// model (plain division plus a countdown per conversion) compared every cycle,
// directed scenarios with hand-computed values, and a randomized phase.
module tb_velocity_unit_converter;

  localparam int W = 32;
  localparam int N = 4;
  localparam longint unsigned MPH = 447039;
  localparam longint unsigned KMH = 277778;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           enable = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [N*W-1:0] velocity = '0;
  logic [N*W-1:0] speed;
  logic [N-1:0]   speed_valid;
  logic           busy;
  logic           scan_done;

  // Small single-channel instance for the narrow-width checks.
  logic       en8 = 1'b0;
  logic [1:0] mode8 = 2'd2;
  logic [7:0] vel8 = 8'd0;
  logic [7:0] speed8;
  logic [0:0] valid8;
  logic       busy8;
  logic       done8;

  int errors = 0;
  int checks = 0;

  velocity_unit_converter dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .velocity(velocity),
    .speed(speed), .speed_valid(speed_valid), .busy(busy), .scan_done(scan_done)
  );

  velocity_unit_converter #(
    .IN_WIDTH(8), .DIV_WIDTH(8), .NUM_CH(1), .MPH_DIV(200), .KMH_DIV(100), .ROUND_NEAREST(1)
  ) dut8 (
    .clk(clk), .rst(rst), .enable(en8), .mode(mode8), .velocity(vel8),
    .speed(speed8), .speed_valid(valid8), .busy(busy8), .scan_done(done8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint unsigned divisor_of(input logic [1:0] md);
    if (md == 2'd0) return MPH;
    else if (md == 2'd1) return KMH;
    else return 1;
  endfunction

  // Unit conversion from first principles: integer divide, round half-up, clamp.
  function automatic longint unsigned convert(input longint unsigned v, input longint unsigned d);
    longint unsigned q, r;
    q = v / d;
    r = v % d;
    if (2 * r >= d) q = q + 1;
    if (q > 64'hFFFF_FFFF) q = 64'hFFFF_FFFF;
    return q;
  endfunction

  // ---------------- behavioural model ----------------
  logic [W-1:0]    m_speed [N];
  logic [N-1:0]    m_valid = '0;
  logic            m_done = 1'b0;
  logic            m_busy = 1'b0;
  bit              m_inflight = 1'b0;
  int              m_left = 0;
  int              m_cur = 0;
  int              m_next = 0;
  longint unsigned m_v = 0;
  longint unsigned m_d = 1;

  initial begin : model
    for (int c = 0; c < N; c++) m_speed[c] = '0;
    forever begin
      @(posedge clk or posedge rst);
      m_valid = '0;
      m_done  = 1'b0;
      if (rst) begin
        for (int c = 0; c < N; c++) m_speed[c] = '0;
        m_inflight = 1'b0;
        m_next     = 0;
        m_busy     = 1'b0;
      end else begin
        if (m_inflight) begin
          m_left--;
          if (m_left == 0) begin
            m_speed[m_cur] = W'(convert(m_v, m_d));
            m_valid[m_cur] = 1'b1;
            m_done         = (m_cur == N - 1);
            m_next         = (m_cur + 1) % N;
            m_inflight     = 1'b0;
          end
        end
        if (!m_inflight && enable) begin
          m_cur      = m_next;
          m_v        = velocity[m_next*W +: W];
          m_d        = divisor_of(mode);
          m_left     = W + 1;
          m_inflight = 1'b1;
        end
        m_busy = m_inflight;
      end
    end
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int c = 0; c < N; c++) begin
          check($sformatf("model_speed%0d", c), speed[c*W +: W], m_speed[c]);
        end
        check("model_valid", speed_valid, m_valid);
        check("model_scan_done", scan_done, m_done);
        check("model_busy", busy, m_busy);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_valid(input int ch, input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!speed_valid[ch] && cycles < limit);
    if (!speed_valid[ch]) begin
      checks++;
      errors++;
      $display("FAIL wait_valid%0d: no pulse within %0d cycles", ch, limit);
    end
  endtask

  task automatic wait_any_valid(input int limit, output int idx);
    int cnt;
    cnt = 0;
    idx = -1;
    do begin
      @(negedge clk);
      cnt++;
    end while (speed_valid == '0 && cnt < limit);
    for (int c = N - 1; c >= 0; c--) if (speed_valid[c]) idx = c;
    if (idx < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_any_valid: no pulse within %0d cycles", limit);
      idx = 0;
    end
  endtask

  task automatic wait_idle(input int limit);
    int cnt;
    cnt = 0;
    while (busy && cnt < limit) begin
      @(negedge clk);
      cnt++;
    end
    check("idle_reached", busy, 1'b0);
  endtask

  // Convert exactly one channel: enable for a single load edge.
  task automatic one_channel(input string name, input logic [1:0] md, input logic [W-1:0] v,
                             input int exp_ch, input logic [W-1:0] exp_val);
    int idx;
    mode     = md;
    velocity = {N{v}};
    enable   = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_any_valid(60, idx);
    check({name, "_channel"}, idx, exp_ch);
    check({name, "_value"}, speed[idx*W +: W], exp_val);
    wait_idle(10);
  endtask

  task automatic small_conv(input string name, input logic [1:0] md, input logic [7:0] v,
                            input logic [7:0] exp_val);
    int cnt;
    mode8 = md;
    vel8  = v;
    en8   = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!valid8[0] && cnt < 20);
    check({name, "_valid"}, valid8[0], 1'b1);
    check({name, "_cycles"}, cnt, 9);
    check({name, "_value"}, speed8, exp_val);
    check({name, "_scan_done"}, done8, 1'b1);
  endtask

  initial begin : stimulus
    int k;
    int pulses;
    longint unsigned t;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_speed", speed, '0);
    check("reset_valid", speed_valid, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_scan_done", scan_done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Full scan in mph with rounding boundary values
    mode     = 2'd0;
    velocity = {32'hFFFF_FFFF, 32'd670558, 32'd670559, 32'd447039};
    enable   = 1'b1;
    wait_valid(0, 60, k);
    check("latency_ch0", k, 34);
    check("mph_447039", speed[0*W +: W], 32'd1);
    wait_valid(1, 60, k);
    check("spacing_ch1", k, 33);
    check("mph_670559", speed[1*W +: W], 32'd2);
    wait_valid(2, 60, k);
    check("spacing_ch2", k, 33);
    check("mph_670558", speed[2*W +: W], 32'd1);
    wait_valid(3, 60, k);
    check("spacing_ch3", k, 33);
    check("mph_max", speed[3*W +: W], 32'd9608);
    check("scan_done_with_ch3", scan_done, 1'b1);
    enable = 1'b0;
    wait_idle(60);

    // Scan resumes at the next channel after enable was dropped
    one_channel("kmh", 2'd1, 32'd27777800, 1, 32'd100);
    one_channel("raw", 2'd2, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF);

    // Mode change mid-conversion only affects the following load
    mode     = 2'd0;
    velocity = {N{32'd27777800}};
    enable   = 1'b1;
    repeat (10) @(negedge clk);
    mode = 2'd1;
    wait_valid(3, 60, k);
    check("switch_ch3_mph", speed[3*W +: W], 32'd62);
    wait_valid(0, 60, k);
    check("switch_ch0_kmh", speed[0*W +: W], 32'd100);
    enable = 1'b0;
    wait_idle(60);

    // Asynchronous reset in the middle of a conversion
    velocity = {32'd5, 32'd6, 32'h1234, 32'd7};
    mode     = 2'd2;
    enable   = 1'b1;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_speed", speed, '0);
    check("async_rst_valid", speed_valid, '0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_scan_done", scan_done, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (speed_valid != '0) pulses++;
    end
    check("no_valid_after_reset", pulses, 0);

    // Randomized phase against the model
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      for (int c = 0; c < N; c++) begin
        case ($urandom_range(0, 3))
          0: velocity[c*W +: W] = $urandom;
          1: velocity[c*W +: W] = '0;
          2: velocity[c*W +: W] = 32'hFFFF_FFFF;
          default: begin
            t = longint'($urandom_range(0, 9000)) * MPH + 223519 + $urandom_range(0, 1);
            velocity[c*W +: W] = t[31:0];
          end
        endcase
      end
    end
    enable = 1'b0;
    wait_idle(200);

    // Narrow single-channel instance
    small_conv("w8_zero", 2'd2, 8'd0, 8'd0);
    small_conv("w8_max", 2'd2, 8'hFF, 8'hFF);
    small_conv("w8_mph", 2'd0, 8'd255, 8'd1);
    small_conv("w8_kmh_half", 2'd1, 8'd150, 8'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/velocity_unit_converter.md
# velocity_unit_converter

Multi-channel, parametrised converter from raw pod velocity (µm/s) to display speed units, the successor to the single-channel fixed-divisor MPH converter. A single shared iterative restoring divider scans all channels round-robin. Each result is optionally rounded to nearest, written to a per-channel output register, and flagged with a one-cycle valid pulse. The block sits between the velocity sources and the telemetry/display formatting logic.

## Interface
- IN_WIDTH, 32: width of each velocity input and speed output.
- DIV_WIDTH, 19: width of the divisor constants. Requires DIV_WIDTH ≤ IN_WIDTH.
- NUM_CH, 4: number of velocity channels, ≥1.
- MPH_DIV, 447039: divisor for mode 0 (µm/s → mph).
- KMH_DIV, 277778: divisor for mode 1 (µm/s → km/h).
- ROUND_NEAREST, 1: 1 = round half-up; 0 = truncate.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- enable  in  1  run the channel scan while high.
- mode  in  2  unit select: 0 mph, 1 km/h, 2/3 raw (divisor 1).
- velocity  in  NUM_CH*IN_WIDTH  channel c occupies bits [c*IN_WIDTH +: IN_WIDTH].
- speed  out  NUM_CH*IN_WIDTH  registered converted speed per channel, same packing.
- speed_valid  out  NUM_CH  one-cycle pulse per channel when its speed word updates.
- busy  out  1  high while state ≠ IDLE.
- scan_done  out  1  one-cycle pulse when channel NUM_CH-1 is stored.

## Operation
- States: IDLE, DIV, STORE. Channel pointer ch ranges 0..NUM_CH-1 and wraps to 0 after NUM_CH-1.
- Load event (IDLE with enable=1, or STORE with enable=1) captures:
  - velocity[ch] into the dividend shift register;
  - the divisor selected by mode at that edge;
  - then clears the remainder, sets the bit counter to IN_WIDTH-1, and goes to DIV.
- DIV: one restoring step per cycle, MSB first.
  - Remainder register is DIV_WIDTH+1 bits wide.
  - rem' = {rem, dividend_msb}; if rem' ≥ divisor, subtract and shift a 1 into the quotient, else shift a 0.
  - After the step with counter = 0, go to STORE.
- STORE:
  - Result q = quotient, plus 1 if ROUND_NEAREST and 2·remainder ≥ divisor.
  - If q+1 would exceed 2^IN_WIDTH−1, saturate to all-ones.
  - Write speed[ch] and pulse speed_valid[ch]; pulse scan_done if ch = NUM_CH-1; advance ch.
  - If enable=1, perform a load event for the new ch in the same edge; otherwise go to IDLE.
- Changing enable or mode mid-conversion has no effect on that conversion.
  - Dropping enable lets the current channel finish, then IDLE. ch is retained, so the scan resumes at the next channel.
  - A mode change applies from the next load event.
- Modes 2/3 use divisor 1: speed = velocity, remainder 0, no rounding.
- Only the channel being stored changes. Other speed words hold their values.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE, ch 0;
  - speed all zeros, speed_valid 0, scan_done 0, busy 0;
  - divider registers cleared.
- Reset mid-DIV abandons the conversion; no valid pulse is issued.
- Take edge E as the load edge for a channel. DIV occupies edges E+1..E+IN_WIDTH. speed/speed_valid/scan_done register at edge E+IN_WIDTH+1, and are visible for the cycle after that edge.
- From IDLE: enable seen high at edge E0 means that edge is the load edge. First speed_valid[0] appears after edge E0+IN_WIDTH+1.
- Continuous enable: one channel per IN_WIDTH+1 cycles; a full scan takes NUM_CH·(IN_WIDTH+1) cycles.
  - Defaults: 33 cycles per channel, 132 cycles per scan.
- busy is high from the cycle after the load edge until the cycle after a STORE that returns to IDLE.
- Velocity inputs are sampled only at load edges and need not be stable otherwise.

## Test plan
- Reset: assert rst asynchronously mid-DIV with speed[1]=0x1234 → all outputs 0 immediately; no speed_valid after release until enable.
- Mode 0, ch0 = 447039, enable one scan → speed[0]=1. speed_valid[0] pulses exactly 33 cycles after the load edge, then ch1..ch3 follow at 33-cycle spacing, and scan_done pulses with ch3.
- Rounding, mode 0:
  - 670559 → 2 (ROUND_NEAREST=1) / 1 (ROUND_NEAREST=0);
  - 670558 → 1 for both;
  - 0xFFFFFFFF → 9608 / 9607.
- Mode 1: 27777800 → 100. Mode 2: 0xDEADBEEF → 0xDEADBEEF. Switch mode 0→1 mid-DIV of ch2 → ch2 uses the mph divisor, ch3 uses the km/h divisor.
- Drop enable mid-DIV of ch1 → ch1 completes and pulses, state goes IDLE, ch2 untouched. Re-enable → next valid pulse is for ch2.
- Saturation: NUM_CH=1, IN_WIDTH=8, mode 2 → speed = velocity, no overflow. Check with velocity 0 → speed 0, valid still pulses.
